// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port RAM command
// interface. A requester locks the RAM with one or more address words and
// releases it with one data word: write data (01) or read request (11).
// After a read, the arbiter waits for the RAM's read data and routes it back
// to the lock owner. Whenever the arbiter returns to idle, priority passes to
// the other requester.
//
// Optional feature: define RAM_ARB_TIMEOUT_EN to add a lock watchdog. If the
// owner makes no progress for TIMEOUT_CYCLES cycles, the watchdog breaks the
// lock.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0_valid/din/ready       requester 0 command channel
//   req1_valid/din/ready       requester 1 command channel
//   resp0_valid/dout           read data returned to requester 0
//   resp1_valid/dout           read data returned to requester 1
//   ram_rx_valid, ram_din      registered command strobe/word to the RAM
//   ram_tx_valid, ram_dout     read data coming back from the RAM
//   err                        one-cycle protocol-error pulse
module ram_arbiter #(
  parameter int WORD_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int DIN_WIDTH     = WORD_SIZE + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [DIN_WIDTH-1:0] req0_din,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DIN_WIDTH-1:0] req1_din,
  output logic                 req1_ready,
  output logic                 resp0_valid,
  output logic [WORD_SIZE-1:0] resp0_dout,
  output logic                 resp1_valid,
  output logic [WORD_SIZE-1:0] resp1_dout,
  output logic                 ram_rx_valid,
  output logic [DIN_WIDTH-1:0] ram_din,
  input  logic                 ram_tx_valid,
  input  logic [WORD_SIZE-1:0] ram_dout,
  output logic                 err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOCK    = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]           state, state_nxt;
  logic                 owner, owner_nxt;
  logic                 prio, prio_nxt;
  logic                 grant;
  logic                 sel;
  logic                 sel_valid;
  logic [DIN_WIDTH-1:0] sel_din;
  logic                 accept;
  logic                 is_data;
  logic                 is_read;
  logic                 fwd;
  logic                 resp_fire;
  logic                 proto_err;

  // In idle, the requester that would be granted. If neither or both
  // requesters are asking, prio decides, so that ready always goes to
  // exactly one side.
  always_comb begin
    if (req0_valid && req1_valid) grant = prio;
    else if (req0_valid)          grant = 1'b0;
    else if (req1_valid)          grant = 1'b1;
    else                          grant = prio;
  end

  assign req0_ready = ((state == IDLE) && !grant) || ((state == LOCK) && !owner);
  assign req1_ready = ((state == IDLE) &&  grant) || ((state == LOCK) &&  owner);

  // Only the requester holding ready can have a word accepted. In idle
  // that is the granted side; in lock it is the owner.
  assign sel       = (state == IDLE) ? grant : owner;
  assign sel_valid = sel ? req1_valid : req0_valid;
  assign sel_din   = sel ? req1_din : req0_din;
  assign accept    = sel_valid && ((state == IDLE) || (state == LOCK));
  assign is_data   = sel_din[DIN_WIDTH-2];
  assign is_read   = sel_din[DIN_WIDTH-1];

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stalled;

  // The owner is stalled in any locked cycle where it neither delivers a
  // word nor receives its read data.
  assign stalled = ((state == LOCK) && !accept) || ((state == WAIT_RD) && !ram_tx_valid);
`endif

  // Transaction sequencing. A data word arriving in idle has no address
  // context, so it is dropped rather than sent to the RAM. A read-data
  // strobe is only meaningful while a read is outstanding.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    fwd       = 1'b0;
    resp_fire = 1'b0;
    proto_err = ram_tx_valid && (state != WAIT_RD);
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_data) begin
            fwd       = 1'b1;
            state_nxt = LOCK;
            owner_nxt = grant;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      LOCK: begin
        if (accept) begin
          fwd = 1'b1;
          if (is_data) begin
            if (is_read) begin
              state_nxt = WAIT_RD;
            end else begin
              state_nxt = IDLE;
              prio_nxt  = ~owner;
            end
          end
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
          prio_nxt  = ~owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef RAM_ARB_TIMEOUT_EN
    if (stalled && (cnt == CNT_LAST)) begin
      state_nxt = IDLE;
      prio_nxt  = ~owner;
      proto_err = 1'b1;
    end
`endif
  end

`ifdef RAM_ARB_TIMEOUT_EN
  // Count consecutive stalled cycles. The counter clears on any progress
  // and whenever the lock is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt == IDLE || !stalled) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`endif

  // State and registered outputs. ram_din and resp*_dout hold their last
  // value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      prio         <= 1'b0;
      ram_rx_valid <= 1'b0;
      ram_din      <= '0;
      resp0_valid  <= 1'b0;
      resp0_dout   <= '0;
      resp1_valid  <= 1'b0;
      resp1_dout   <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      prio         <= prio_nxt;
      ram_rx_valid <= fwd;
      if (fwd) ram_din <= sel_din;
      resp0_valid  <= resp_fire && !owner;
      resp1_valid  <= resp_fire && owner;
      if (resp_fire && !owner) resp0_dout <= ram_dout;
      if (resp_fire && owner)  resp1_dout <= ram_dout;
      err          <= proto_err;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter. The stimulus process
// drives word-level transactions and a simple RAM responder. It predicts
// ready, RAM strobes, responses and error pulses from a transaction-level
// model of the arbitration rules, and queues each prediction with the cycle
// in which it must appear. A separate monitor pops and compares predictions
// whenever the DUT shows an output.
module tb_ram_arbiter;
  localparam int WS = 8;
  localparam int DW = WS + 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_din, req1_din;
  logic          resp0_valid, resp1_valid;
  logic [WS-1:0] resp0_dout, resp1_dout;
  logic          ram_rx_valid, ram_tx_valid, err;
  logic [DW-1:0] ram_din;
  logic [WS-1:0] ram_dout;

  ram_arbiter #(.WORD_SIZE(WS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_din(req0_din), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_din(req1_din), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_dout(resp0_dout),
    .resp1_valid(resp1_valid), .resp1_dout(resp1_dout),
    .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            stamp;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_ram[$], exp_resp0[$], exp_resp1[$];
  int   exp_err[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: who holds the RAM (-1 = nobody), whether a read is
  // outstanding, whose turn it is, and the watchdog's stall count.
  int holder = -1;
  bit read_pending = 1'b0;
  bit turn = 1'b0;
  int stall = 0;

  logic [DW-1:0] wq0[$], wq1[$];
  int gap0 = 0, gap1 = 0;
  int rd_cnt = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, actual, required);
    end
  endtask

  // Queue one random transaction for a requester. Occasionally the
  // transaction is a lone data word, which must be rejected as an error.
  task automatic genTxn(input int who);
    logic [DW-1:0] w;
    int n;
    n = $urandom_range(1, 3);
    if ($urandom_range(0, 7) == 0) n = 0;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      w[DW-2] = 1'b0;
      if (who == 0) wq0.push_back(w); else wq1.push_back(w);
    end
    w = DW'($urandom);
    w[DW-2] = 1'b1;
    if (who == 0) wq0.push_back(w); else wq1.push_back(w);
  endtask

  // Run cycles: drive requesters and the RAM responder, predict ready,
  // and push expected outputs for the next edge.
  task automatic applyStimulus(input int ncycles, input bit random_mode);
    bit r0, r1, acc0, acc1, moved, errx;
    int g, held;
    logic [DW-1:0] w;
    exp_t e;
    for (int n = 0; n < ncycles; n++) begin
      @(negedge clk);
      if (random_mode) begin
        if (wq0.size() < 3 && $urandom_range(0, 3) == 0) genTxn(0);
        if (wq1.size() < 3 && $urandom_range(0, 3) == 0) genTxn(1);
      end
      ram_tx_valid = 1'b0;
      ram_dout = WS'($urandom);
      if (ram_rx_valid && ram_din[DW-1:DW-2] == 2'b11)
        rd_cnt = random_mode ? int'($urandom_range(0, 2)) : 0;
      if (rd_cnt == 0) begin
        ram_tx_valid = 1'b1;
        rd_cnt = -1;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
      end else if (random_mode && !read_pending && $urandom_range(0, 19) == 0) begin
        ram_tx_valid = 1'b1;
      end
      req0_valid = (wq0.size() > 0) && (gap0 == 0);
      req0_din   = req0_valid ? wq0[0] : DW'($urandom);
      if (gap0 > 0) gap0--;
      req1_valid = (wq1.size() > 0) && (gap1 == 0);
      req1_din   = req1_valid ? wq1[0] : DW'($urandom);
      if (gap1 > 0) gap1--;
      #1;
      r0 = 1'b0;
      r1 = 1'b0;
      if (!read_pending) begin
        if (holder >= 0) begin
          r0 = (holder == 0);
          r1 = (holder == 1);
        end else begin
          if (req0_valid && req1_valid) g = int'(turn);
          else if (req0_valid)          g = 0;
          else if (req1_valid)          g = 1;
          else                          g = int'(turn);
          r0 = (g == 0);
          r1 = (g == 1);
        end
      end
      checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, r0});
      checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, r1});
      acc0 = req0_valid && r0;
      acc1 = req1_valid && r1;
      moved = 1'b0;
      errx = 1'b0;
      held = holder;
      if (read_pending) begin
        if (ram_tx_valid) begin
          e.stamp = cyc + 1;
          e.data = DW'(ram_dout);
          if (holder == 0) exp_resp0.push_back(e); else exp_resp1.push_back(e);
          turn = (holder == 0);
          holder = -1;
          read_pending = 1'b0;
          moved = 1'b1;
        end
      end else begin
        if (ram_tx_valid) errx = 1'b1;
        if (acc0 || acc1) begin
          w = acc1 ? req1_din : req0_din;
          if (acc1) begin
            void'(wq1.pop_front());
            gap1 = (random_mode && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
          end else begin
            void'(wq0.pop_front());
            gap0 = (random_mode && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
          end
          if (holder < 0 && w[DW-2]) begin
            errx = 1'b1;
          end else begin
            e.stamp = cyc + 1;
            e.data = w;
            exp_ram.push_back(e);
            moved = 1'b1;
            if (holder < 0) begin
              holder = acc1 ? 1 : 0;
            end else if (w[DW-2]) begin
              if (w[DW-1]) begin
                read_pending = 1'b1;
              end else begin
                turn = (holder == 0);
                holder = -1;
              end
            end
          end
        end
      end
`ifdef RAM_ARB_TIMEOUT_EN
      if (held >= 0 && !moved) begin
        stall++;
        if (stall == TO) begin
          turn = (held == 0);
          holder = -1;
          read_pending = 1'b0;
          errx = 1'b1;
          stall = 0;
        end
      end
`endif
      if (moved) stall = 0;
      if (errx) exp_err.push_back(cyc + 1);
    end
  endtask

  // Monitor: whenever an output strobes, or a prediction falls due, pop the
  // next prediction and compare its value and its cycle.
  always @(negedge clk) begin : monitor
    exp_t m;
    int t;
    if (rst_n) begin
      if (ram_rx_valid || (exp_ram.size() > 0 && exp_ram[0].stamp <= cyc)) begin
        if (exp_ram.size() == 0) checkOutput("ram_rx_valid", {31'd0, ram_rx_valid}, 32'd0);
        else begin
          m = exp_ram.pop_front();
          checkOutput("ram_rx_valid", {31'd0, ram_rx_valid}, 32'd1);
          checkOutput("ram_rx_cycle", cyc, m.stamp);
          checkOutput("ram_din", {22'd0, ram_din}, {22'd0, m.data});
        end
      end
      if (resp0_valid || (exp_resp0.size() > 0 && exp_resp0[0].stamp <= cyc)) begin
        if (exp_resp0.size() == 0) checkOutput("resp0_valid", {31'd0, resp0_valid}, 32'd0);
        else begin
          m = exp_resp0.pop_front();
          checkOutput("resp0_valid", {31'd0, resp0_valid}, 32'd1);
          checkOutput("resp0_cycle", cyc, m.stamp);
          checkOutput("resp0_dout", {24'd0, resp0_dout}, {22'd0, m.data});
        end
      end
      if (resp1_valid || (exp_resp1.size() > 0 && exp_resp1[0].stamp <= cyc)) begin
        if (exp_resp1.size() == 0) checkOutput("resp1_valid", {31'd0, resp1_valid}, 32'd0);
        else begin
          m = exp_resp1.pop_front();
          checkOutput("resp1_valid", {31'd0, resp1_valid}, 32'd1);
          checkOutput("resp1_cycle", cyc, m.stamp);
          checkOutput("resp1_dout", {24'd0, resp1_dout}, {22'd0, m.data});
        end
      end
      if (err || (exp_err.size() > 0 && exp_err[0] <= cyc)) begin
        if (exp_err.size() == 0) checkOutput("err", {31'd0, err}, 32'd0);
        else begin
          t = exp_err.pop_front();
          checkOutput("err", {31'd0, err}, 32'd1);
          checkOutput("err_cycle", cyc, t);
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ram_rx_valid"}, {31'd0, ram_rx_valid}, 32'd0);
    checkOutput({tag, "_ram_din"}, {22'd0, ram_din}, 32'd0);
    checkOutput({tag, "_resp0_valid"}, {31'd0, resp0_valid}, 32'd0);
    checkOutput({tag, "_resp1_valid"}, {31'd0, resp1_valid}, 32'd0);
    checkOutput({tag, "_resp0_dout"}, {24'd0, resp0_dout}, 32'd0);
    checkOutput({tag, "_resp1_dout"}, {24'd0, resp1_dout}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_din = '0; req1_din = '0;
    ram_tx_valid = 1'b0; ram_dout = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] write: req0 0x012, 0x155");
    wq0 = '{10'h012, 10'h155};
    applyStimulus(6, 1'b0);

    $display("[TB] read: req1 0x212, 0x300");
    wq1 = '{10'h212, 10'h300};
    applyStimulus(8, 1'b0);

    $display("[TB] stray data word from idle: req0 0x1AA");
    wq0 = '{10'h1AA};
    applyStimulus(3, 1'b0);

    $display("[TB] contention with prio on req0");
    wq0 = '{10'h012, 10'h155};
    wq1 = '{10'h212, 10'h300};
    applyStimulus(12, 1'b0);

    $display("[TB] reset while locked");
    wq0 = '{10'h010, 10'h011};
    applyStimulus(2, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkResetOutputs("async");
    checkOutput("async_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("async_req1_ready", {31'd0, req1_ready}, 32'd0);
    wq0.delete(); wq1.delete();
    exp_ram.delete(); exp_resp0.delete(); exp_resp1.delete(); exp_err.delete();
    holder = -1; read_pending = 1'b0; turn = 1'b0; stall = 0; rd_cnt = -1;
    gap0 = 0; gap1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq1 = '{10'h212, 10'h300};
    applyStimulus(8, 1'b0);

`ifdef RAM_ARB_TIMEOUT_EN
    $display("[TB] watchdog: req0 locks then stalls");
    wq0 = '{10'h010};
    applyStimulus(2, 1'b0);
    wq1 = '{10'h212, 10'h300};
    applyStimulus(TO + 10, 1'b0);
`endif

    $display("[TB] randomized traffic");
    applyStimulus(800, 1'b1);
    wq0.delete(); wq1.delete();
    applyStimulus(30, 1'b0);
    checkOutput("drain_ram", exp_ram.size(), 32'd0);
    checkOutput("drain_resp0", exp_resp0.size(), 32'd0);
    checkOutput("drain_resp1", exp_resp1.size(), 32'd0);
    checkOutput("drain_err", exp_err.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
